// File: rtl/snn_job_sequencer_if.sv
// snn_job_sequencer_if: UART RX, input-RAM, snn_core, UART TX and status signals of the job sequencer
interface snn_job_sequencer_if #(parameter int ADDR_W = 10);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_wdata;
  logic              core_start;
  logic [ADDR_W-1:0] core_addr;
  logic              core_done;
  logic [3:0]        core_digit;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [3:0]        led;
  logic              busy;
  modport master (
    input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    output clr_rx_rdy, ram_addr, ram_we, ram_wdata, core_start, tx_start, tx_data, led, busy
  );
  modport slave (
    output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    input  clr_rx_rdy, ram_addr, ram_we, ram_wdata, core_start, tx_start, tx_data, led, busy
  );
endinterface

// File: rtl/snn_job_sequencer.sv
// snn_job_sequencer: loads a UART image into input RAM, runs snn_core, reports the digit over UART.
// Optional RUN watchdog enabled by defining SNN_SEQ_TIMEOUT_EN.
module snn_job_sequencer #(
  parameter int N_INPUTS    = 784,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 32768
) (
  input logic clk,
  input logic rst_n,
  snn_job_sequencer_if.master bus
);
  localparam logic [2:0] LOAD   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] REPORT = 3'd4;
  localparam logic [ADDR_W:0] N_MAX = N_INPUTS[ADDR_W:0];
  logic [2:0]      state;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] cnt_nxt;
  logic [7:0]      shreg;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [3:0]      led;
  logic            timeout;
  assign cnt_nxt = cnt + 1'b1;
`ifdef SNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] rcnt;
  // Counter sits at zero outside RUN, so it is cleared on every RUN entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rcnt <= '0;
    else rcnt <= (state == RUN) ? rcnt + 1'b1 : '0;
  assign timeout = (state == RUN) && (rcnt == TO_MAX);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= '0;
      shreg    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      led      <= 4'h0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        LOAD:
          if (bus.rx_rdy) begin
            shreg <= bus.rx_data;
            state <= UNPACK;
          end
        UNPACK: begin
          shreg <= shreg >> 1;
          cnt   <= cnt_nxt;
          if (cnt[2:0] == 3'd7) state <= (cnt_nxt >= N_MAX) ? START : LOAD;
        end
        START: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN:
          if (bus.core_done) begin
            led     <= bus.core_digit;
            tx_data <= {4'h3, bus.core_digit};
            state   <= REPORT;
          end else if (timeout) begin
            led     <= 4'hF;
            tx_data <= 8'h45;
            state   <= REPORT;
          end
        REPORT:
          if (!bus.tx_busy) begin
            tx_start <= 1'b1;
            state    <= LOAD;
          end
        default: state <= LOAD;
      endcase
    end
  assign bus.clr_rx_rdy = (state == LOAD) && bus.rx_rdy;
  assign bus.ram_addr   = (state == RUN || state == REPORT) ? bus.core_addr : cnt[ADDR_W-1:0];
  assign bus.ram_we     = (state == UNPACK) && (cnt < N_MAX);
  assign bus.ram_wdata  = (state == UNPACK) && shreg[0];
  assign bus.core_start = (state == START);
  assign bus.tx_start   = tx_start;
  assign bus.tx_data    = tx_data;
  assign bus.led        = led;
  assign bus.busy       = !((state == LOAD) && (cnt == '0));
endmodule

// File: tb/tb_snn_job_sequencer.sv
// tb_snn_job_sequencer: directed scenarios for the image-load / run / report job sequencer
module tb_snn_job_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  snn_job_sequencer_if #(.ADDR_W(10)) bus();
  snn_job_sequencer #(.N_INPUTS(784), .ADDR_W(10), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  logic mem [0:1023];
  int   tag [0:1023];
  int total = 0, bad = 0, job = 0;
  int cyc = 0, writes = 0, clrs = 0, starts = 0, txs = 0;
  int clr_cyc = 0, start_cyc = 0, tx_cyc = 0;
  logic [7:0] tx_byte = 8'h00;
  // Observes the pre-edge values that each rising edge acts on; cyc indexes the edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      tag[bus.ram_addr] <= job;
      writes <= writes + 1;
    end
    if (bus.clr_rx_rdy) begin clrs <= clrs + 1; clr_cyc <= cyc; end
    if (bus.core_start) begin starts <= starts + 1; start_cyc <= cyc; end
    if (bus.tx_start) begin txs <= txs + 1; tx_cyc <= cyc; tx_byte <= bus.tx_data; end
  end
  task automatic tick();
    @(negedge clk);
    #2;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_rdy = 1'b1;
    bus.rx_data = b;
    #1;
    while (!bus.clr_rx_rdy && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL rx_handshake got=no_clr want=clr"); end
    tick();
    bus.rx_rdy = 1'b0;
  endtask
  task automatic wait_start(input int target);
    int n = 0;
    while (starts < target && n < 100) begin tick(); n++; end
    total++;
    if (starts !== target) begin bad++; $display("FAIL core_start_count got=%0d want=%0d", starts, target); end
  endtask
  task automatic load_job(input logic [7:0] b, input int nbytes);
    int s0 = starts;
    for (int i = 0; i < nbytes; i++) send_byte(b);
    wait_start(s0 + 1);
  endtask
  task automatic pulse_done(input logic [3:0] d, output int dcyc);
    bus.core_done = 1'b1;
    bus.core_digit = d;
    dcyc = cyc;
    tick();
    bus.core_done = 1'b0;
  endtask
  task automatic wait_tx(input int target);
    int n = 0;
    while (txs < target && n < 200) begin tick(); n++; end
    total++;
    if (txs !== target) begin bad++; $display("FAIL tx_start_count got=%0d want=%0d", txs, target); end
  endtask
  task automatic check_image(input string name, input logic [7:0] first, input logic [7:0] rest);
    int err = 0;
    for (int a = 0; a < 784; a++)
      if (tag[a] != job || mem[a] !== (a < 8 ? first[a % 8] : rest[a % 8])) err++;
    total++;
    if (err != 0) begin bad++; $display("FAIL %s got=%0d_bad_bits want=0", name, err); end
  endtask
  task automatic test_reset();
    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.core_addr = '0; bus.core_done = 1'b0;
    bus.core_digit = 4'h0; bus.tx_busy = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.clr_rx_rdy, bus.ram_we, bus.ram_wdata, bus.core_start, bus.tx_start} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses got=%b want=00000",
        {bus.clr_rx_rdy, bus.ram_we, bus.ram_wdata, bus.core_start, bus.tx_start});
    end
    total++;
    if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
    total++;
    if (bus.led !== 4'h0) begin bad++; $display("FAIL reset_led got=%h want=0", bus.led); end
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.ram_addr !== 10'd0) begin
      bad++; $display("FAIL reset_idle got=busy%b_addr%0d want=busy0_addr0", bus.busy, bus.ram_addr);
    end
  endtask
  task automatic test_load();
    int w0 = writes;
    job = 1;
    load_job(8'hA5, 98);
    total++;
    if (writes - w0 !== 784) begin bad++; $display("FAIL load_writes got=%0d want=784", writes - w0); end
    total++;
    if (start_cyc - clr_cyc !== 9) begin bad++; $display("FAIL start_latency got=%0d want=9", start_cyc - clr_cyc); end
    total++;
    if ({mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]} !== 8'hA5) begin
      bad++; $display("FAIL load_first_byte got=%b want=10100101",
        {mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]});
    end
    check_image("load_image", 8'hA5, 8'hA5);
    bus.core_addr = 10'h2AB;
    #1;
    total++;
    if (bus.ram_addr !== 10'h2AB || bus.ram_we !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL run_mux got=addr%h_we%b_busy%b want=addr2ab_we0_busy1", bus.ram_addr, bus.ram_we, bus.busy);
    end
    repeat (5) tick();
    total++;
    if (starts !== 1) begin bad++; $display("FAIL single_start got=%0d want=1", starts); end
  endtask
  task automatic test_result();
    int d;
    pulse_done(4'h7, d);
    wait_tx(1);
    total++;
    if (tx_byte !== 8'h37 || bus.led !== 4'h7) begin
      bad++; $display("FAIL result_digit got=tx%h_led%h want=tx37_led7", tx_byte, bus.led);
    end
    total++;
    if (tx_cyc - d !== 2) begin bad++; $display("FAIL done_to_tx got=%0d want=2", tx_cyc - d); end
    repeat (5) tick();
    total++;
    if (txs !== 1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL result_single got=txs%0d_busy%b want=txs1_busy0", txs, bus.busy);
    end
  endtask
  task automatic test_tx_busy();
    int d, r, t0;
    job = 2;
    load_job(8'h3C, 98);
    check_image("busy_image", 8'h3C, 8'h3C);
    t0 = txs;
    bus.tx_busy = 1'b1;
    pulse_done(4'h2, d);
    repeat (49) tick();
    total++;
    if (txs !== t0) begin bad++; $display("FAIL tx_held got=%0d want=%0d", txs, t0); end
    r = cyc;
    bus.tx_busy = 1'b0;
    wait_tx(t0 + 1);
    total++;
    if (tx_cyc !== r + 1 || tx_byte !== 8'h32 || bus.led !== 4'h2) begin
      bad++; $display("FAIL tx_release got=cyc%0d_tx%h_led%h want=cyc%0d_tx32_led2", tx_cyc, tx_byte, bus.led, r + 1);
    end
    repeat (5) tick();
    total++;
    if (txs !== t0 + 1) begin bad++; $display("FAIL tx_busy_single got=%0d want=%0d", txs, t0 + 1); end
  endtask
  task automatic test_rx_during_run();
    int d, c0, t0, w0;
    job = 3;
    load_job(8'hA5, 98);
    c0 = clrs;
    t0 = txs;
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'h0F;
    repeat (20) tick();
    total++;
    if (clrs !== c0) begin bad++; $display("FAIL rx_in_run got=%0d want=%0d", clrs, c0); end
    job = 4;
    w0 = writes;
    pulse_done(4'h9, d);
    wait_tx(t0 + 1);
    bus.rx_rdy = 1'b0;
    total++;
    if (clrs !== c0 + 1 || clr_cyc !== d + 2 || tx_byte !== 8'h39) begin
      bad++; $display("FAIL pending_byte got=clrs%0d_cyc%0d_tx%h want=clrs%0d_cyc%0d_tx39",
        clrs, clr_cyc, tx_byte, c0 + 1, d + 2);
    end
    load_job(8'hFF, 97);
    total++;
    if (writes - w0 !== 784) begin bad++; $display("FAIL pending_writes got=%0d want=784", writes - w0); end
    check_image("pending_image", 8'h0F, 8'hFF);
    pulse_done(4'h1, d);
    wait_tx(t0 + 2);
  endtask
  task automatic test_reset_mid();
    int d, t0, w0, n;
    job = 5;
    for (int i = 0; i < 40; i++) send_byte(8'(i));
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'hC3;
    n = 0;
    #1;
    while (!bus.clr_rx_rdy && n < 50) begin tick(); n++; end
    tick();
    bus.rx_rdy = 1'b0;
    repeat (3) tick();
    t0 = txs;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.ram_we, bus.ram_wdata, bus.core_start, bus.busy, bus.led, bus.tx_data} !== 16'h0 || bus.ram_addr !== 10'd0) begin
      bad++; $display("FAIL mid_reset got=we%b_busy%b_led%h_tx%h_addr%0d want=all_zero",
        bus.ram_we, bus.busy, bus.led, bus.tx_data, bus.ram_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (txs !== t0) begin bad++; $display("FAIL mid_reset_tx got=%0d want=%0d", txs, t0); end
    job = 6;
    w0 = writes;
    load_job(8'h5A, 98);
    total++;
    if (writes - w0 !== 784) begin bad++; $display("FAIL rejob_writes got=%0d want=784", writes - w0); end
    check_image("rejob_image", 8'h5A, 8'h5A);
    pulse_done(4'h4, d);
    wait_tx(t0 + 1);
    total++;
    if (tx_byte !== 8'h34 || bus.led !== 4'h4) begin
      bad++; $display("FAIL rejob_result got=tx%h_led%h want=tx34_led4", tx_byte, bus.led);
    end
  endtask
`ifdef SNN_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    job = 7;
    load_job(8'h00, 98);
    t0 = txs;
    wait_tx(t0 + 1);
    total++;
    if (tx_cyc - start_cyc !== 102 || tx_byte !== 8'h45 || bus.led !== 4'hF) begin
      bad++; $display("FAIL timeout got=lat%0d_tx%h_led%h want=lat102_tx45_ledf", tx_cyc - start_cyc, tx_byte, bus.led);
    end
  endtask
`else
  task automatic test_no_timeout();
    int d, t0;
    job = 7;
    load_job(8'h00, 98);
    t0 = txs;
    repeat (300) tick();
    total++;
    if (txs !== t0) begin bad++; $display("FAIL no_timeout got=%0d want=%0d", txs, t0); end
    pulse_done(4'h0, d);
    wait_tx(t0 + 1);
    total++;
    if (tx_byte !== 8'h30) begin bad++; $display("FAIL late_done got=%h want=30", tx_byte); end
  endtask
`endif
  initial begin
    test_reset();
    test_load();
    test_result();
    test_tx_busy();
    test_rx_during_run();
    test_reset_mid();
`ifdef SNN_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
